// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and default widths for the two-requester memory port arbiter.
// The owner tag records which requester issued each in-flight read.
package mem_port_arbiter_pkg;

  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 32;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DMA = 1'b1
  } owner_e;

  typedef struct packed {
    logic   valid;
    owner_e owner;
  } rd_tag_t;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the CPU-side, DMA-side and shared RAM-side signals of the arbiter.
// The slave modport is the arbiter's view; master is everything around it.
interface mem_port_arbiter_if
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;

  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;

  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic              ram_we;
  logic              ram_re;
  logic [DATA_W-1:0] ram_rdata;
  logic              busy;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_req, dma_we, dma_addr, dma_wdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output ram_addr, ram_wdata, ram_we, ram_re, busy,
    input  ram_rdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_req, dma_we, dma_addr, dma_wdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  ram_addr, ram_wdata, ram_we, ram_re, busy,
    output ram_rdata
  );

endinterface

// File: rtl/mem_port_arbiter_rd_tag_pipe.sv
// Owner-tag shift register matching the RAM read latency; the tag leaving the
// last slot marks the cycle in which ram_rdata belongs to that owner.
module rd_tag_pipe
  import mem_port_arbiter_pkg::*;
#(
  parameter int RD_LAT = 1
) (
  input  logic   clock,
  input  logic   reset,
  input  logic   push,
  input  owner_e push_owner,
  output logic   pop_valid,
  output owner_e pop_owner,
  output logic   busy
);

  rd_tag_t slots [RD_LAT];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RD_LAT; i++) begin
        slots[i] <= '{valid: 1'b0, owner: OWN_CPU};
      end
    end else begin
      slots[0] <= '{valid: push, owner: push_owner};
      for (int i = 1; i < RD_LAT; i++) begin
        slots[i] <= slots[i-1];
      end
    end
  end

  always_comb begin
    pop_valid = slots[RD_LAT-1].valid;
    pop_owner = slots[RD_LAT-1].owner;
    busy      = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      busy = busy | slots[i].valid;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one RAM port between a CPU and a DMA requester,
// with owner-tagged routing of read data back to whoever issued the read.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input logic               clock,
  input logic               reset,
  mem_port_arbiter_if.slave bus
);

  owner_e            last_gnt;
  owner_e            gnt_owner;
  owner_e            pop_owner;
  logic              cpu_gnt;
  logic              dma_gnt;
  logic              ram_re;
  logic              pop_valid;
  logic              cpu_rv;
  logic              dma_rv;
  logic [DATA_W-1:0] cpu_hold;
  logic [DATA_W-1:0] dma_hold;

  // On a tie the requester that did not complete the previous access wins.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (reset) begin
      if (bus.cpu_req && (!bus.dma_req || last_gnt == OWN_DMA)) begin
        cpu_gnt = 1'b1;
      end else if (bus.dma_req) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    gnt_owner     = dma_gnt ? OWN_DMA : OWN_CPU;
    bus.cpu_gnt   = cpu_gnt;
    bus.dma_gnt   = dma_gnt;
    bus.ram_addr  = {ADDR_W{1'b0}};
    bus.ram_wdata = {DATA_W{1'b0}};
    bus.ram_we    = 1'b0;
    ram_re        = 1'b0;
    if (cpu_gnt) begin
      bus.ram_addr  = bus.cpu_addr;
      bus.ram_wdata = bus.cpu_wdata;
      bus.ram_we    = bus.cpu_we;
      ram_re        = !bus.cpu_we;
    end else if (dma_gnt) begin
      bus.ram_addr  = bus.dma_addr;
      bus.ram_wdata = bus.dma_wdata;
      bus.ram_we    = bus.dma_we;
      ram_re        = !bus.dma_we;
    end
    bus.ram_re = ram_re;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      last_gnt <= OWN_DMA;
    end else if (cpu_gnt) begin
      last_gnt <= OWN_CPU;
    end else if (dma_gnt) begin
      last_gnt <= OWN_DMA;
    end
  end

  rd_tag_pipe #(.RD_LAT(RD_LAT)) u_rd_tag_pipe (
    .clock      (clock),
    .reset      (reset),
    .push       (ram_re),
    .push_owner (gnt_owner),
    .pop_valid  (pop_valid),
    .pop_owner  (pop_owner),
    .busy       (bus.busy)
  );

  // Read data is passed straight through on its return cycle and held afterwards.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cpu_hold <= {DATA_W{1'b0}};
      dma_hold <= {DATA_W{1'b0}};
    end else begin
      if (cpu_rv) cpu_hold <= bus.ram_rdata;
      if (dma_rv) dma_hold <= bus.ram_rdata;
    end
  end

  always_comb begin
    cpu_rv         = pop_valid && (pop_owner == OWN_CPU);
    dma_rv         = pop_valid && (pop_owner == OWN_DMA);
    bus.cpu_rvalid = cpu_rv;
    bus.dma_rvalid = dma_rv;
    bus.cpu_rdata  = cpu_rv ? bus.ram_rdata : cpu_hold;
    bus.dma_rdata  = dma_rv ? bus.ram_rdata : dma_hold;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter at read latencies 1, 2 and 4, each
// instance backed by a small behavioural RAM with matching latency.
module tb_mem_port_arbiter;

  logic clock;
  logic reset;
  int   tests_run;
  int   tests_failed;

  mem_port_arbiter_if bus1 ();
  mem_port_arbiter_if bus2 ();
  mem_port_arbiter_if bus4 ();

  mem_port_arbiter #(.RD_LAT(1)) u_dut1 (.clock(clock), .reset(reset), .bus(bus1));
  mem_port_arbiter #(.RD_LAT(2)) u_dut2 (.clock(clock), .reset(reset), .bus(bus2));
  mem_port_arbiter #(.RD_LAT(4)) u_dut4 (.clock(clock), .reset(reset), .bus(bus4));

  always #5 clock = ~clock;

  function automatic logic [31:0] mem_init(input int a);
    return 32'hC0DE_0000 | 32'(a);
  endfunction

  // Behavioural RAMs: contents reload while reset is low, reads return after the latency.
  logic [31:0] mem1 [256];
  logic [31:0] mem2 [256];
  logic [31:0] mem4 [256];
  logic [31:0] pipe1 [4];
  logic [31:0] pipe2 [4];
  logic [31:0] pipe4 [4];

  always @(posedge clock) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) begin
        mem1[i] <= mem_init(i);
        mem2[i] <= mem_init(i);
        mem4[i] <= mem_init(i);
      end
    end else begin
      if (bus1.ram_we) mem1[bus1.ram_addr] <= bus1.ram_wdata;
      if (bus2.ram_we) mem2[bus2.ram_addr] <= bus2.ram_wdata;
      if (bus4.ram_we) mem4[bus4.ram_addr] <= bus4.ram_wdata;
    end
    pipe1[0] <= bus1.ram_re ? mem1[bus1.ram_addr] : 32'hDEAD_BEEF;
    pipe2[0] <= bus2.ram_re ? mem2[bus2.ram_addr] : 32'hDEAD_BEEF;
    pipe4[0] <= bus4.ram_re ? mem4[bus4.ram_addr] : 32'hDEAD_BEEF;
    for (int i = 1; i < 4; i++) begin
      pipe1[i] <= pipe1[i-1];
      pipe2[i] <= pipe2[i-1];
      pipe4[i] <= pipe4[i-1];
    end
  end

  assign bus1.ram_rdata = pipe1[0];
  assign bus2.ram_rdata = pipe2[1];
  assign bus4.ram_rdata = pipe4[3];

  task automatic check_output(input string tag, input logic [63:0] observed,
                              input logic [63:0] expected);
    tests_run++;
    if (observed !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drives both requesters of the latency-1 instance for one cycle, then settles.
  task automatic apply_stimulus(input logic c_req, input logic c_we,
                                input logic [7:0] c_addr, input logic [31:0] c_wdata,
                                input logic d_req, input logic d_we,
                                input logic [7:0] d_addr, input logic [31:0] d_wdata);
    @(negedge clock);
    bus1.cpu_req   = c_req;
    bus1.cpu_we    = c_we;
    bus1.cpu_addr  = c_addr;
    bus1.cpu_wdata = c_wdata;
    bus1.dma_req   = d_req;
    bus1.dma_we    = d_we;
    bus1.dma_addr  = d_addr;
    bus1.dma_wdata = d_wdata;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  int c_cnt;
  int d_cnt;
  int rv_c;
  int rv_d;
  logic active;

  initial begin
    clock = 1'b0;
    reset = 1'b0;
    tests_run = 0;
    tests_failed = 0;
    {bus1.cpu_req, bus1.cpu_we, bus1.dma_req, bus1.dma_we} = '0;
    {bus2.cpu_req, bus2.cpu_we, bus2.dma_req, bus2.dma_we} = '0;
    {bus4.cpu_req, bus4.cpu_we, bus4.dma_req, bus4.dma_we} = '0;
    {bus1.cpu_addr, bus1.dma_addr, bus2.cpu_addr, bus2.dma_addr} = '0;
    {bus4.cpu_addr, bus4.dma_addr} = '0;
    {bus1.cpu_wdata, bus1.dma_wdata, bus2.cpu_wdata, bus2.dma_wdata} = '0;
    {bus4.cpu_wdata, bus4.dma_wdata} = '0;

    // Requests raised during reset must not produce grants or strobes.
    bus1.cpu_req = 1'b1;
    bus1.dma_req = 1'b1;
    @(negedge clock);
    @(negedge clock);
    #1;
    check_output("rst_cpu_gnt", bus1.cpu_gnt, 1'b0);
    check_output("rst_dma_gnt", bus1.dma_gnt, 1'b0);
    check_output("rst_ram_re", bus1.ram_re, 1'b0);
    check_output("rst_ram_we", bus1.ram_we, 1'b0);
    check_output("rst_busy", bus1.busy, 1'b0);
    check_output("rst_cpu_rvalid", bus1.cpu_rvalid, 1'b0);
    check_output("rst_cpu_rdata", bus1.cpu_rdata, 32'h0);
    bus1.cpu_req = 1'b0;
    bus1.dma_req = 1'b0;
    reset = 1'b1;

    // CPU write then read back.
    apply_stimulus(1, 1, 8'h10, 32'h1234_5678, 0, 0, 8'h00, 32'h0);
    check_output("wr_cpu_gnt", bus1.cpu_gnt, 1'b1);
    check_output("wr_ram_we", bus1.ram_we, 1'b1);
    check_output("wr_ram_re", bus1.ram_re, 1'b0);
    check_output("wr_ram_addr", bus1.ram_addr, 8'h10);
    check_output("wr_ram_wdata", bus1.ram_wdata, 32'h1234_5678);
    apply_stimulus(1, 0, 8'h10, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("rd_cpu_gnt", bus1.cpu_gnt, 1'b1);
    check_output("rd_ram_re", bus1.ram_re, 1'b1);
    check_output("wr_no_rvalid", bus1.cpu_rvalid, 1'b0);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("rd_cpu_rvalid", bus1.cpu_rvalid, 1'b1);
    check_output("rd_cpu_rdata", bus1.cpu_rdata, 32'h1234_5678);
    check_output("rd_busy", bus1.busy, 1'b1);
    check_output("rd_dma_rvalid", bus1.dma_rvalid, 1'b0);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("rd_rvalid_drop", bus1.cpu_rvalid, 1'b0);
    check_output("rd_rdata_hold", bus1.cpu_rdata, 32'h1234_5678);
    check_output("rd_busy_drop", bus1.busy, 1'b0);

    // First tie after reset goes to the CPU, then the DMA.
    do_reset();
    apply_stimulus(1, 0, 8'h05, 32'h0, 1, 0, 8'h06, 32'h0);
    check_output("tie_cpu_gnt", bus1.cpu_gnt, 1'b1);
    check_output("tie_dma_gnt0", bus1.dma_gnt, 1'b0);
    check_output("tie_addr_cpu", bus1.ram_addr, 8'h05);
    apply_stimulus(0, 0, 8'h00, 32'h0, 1, 0, 8'h06, 32'h0);
    check_output("tie_dma_gnt", bus1.dma_gnt, 1'b1);
    check_output("tie_addr_dma", bus1.ram_addr, 8'h06);
    check_output("tie_cpu_rvalid", bus1.cpu_rvalid, 1'b1);
    check_output("tie_cpu_rdata", bus1.cpu_rdata, mem_init(8'h05));
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("tie_dma_rvalid", bus1.dma_rvalid, 1'b1);
    check_output("tie_dma_rdata", bus1.dma_rdata, mem_init(8'h06));
    check_output("tie_cpu_rv_off", bus1.cpu_rvalid, 1'b0);

    // Both read continuously for 8 cycles: strict alternation, in-order returns.
    c_cnt = 0;
    d_cnt = 0;
    rv_c = 0;
    rv_d = 0;
    for (int i = 0; i < 10; i++) begin
      active = (i < 8);
      apply_stimulus(active, 0, 8'(8'h40 + c_cnt), 32'h0, active, 0, 8'(8'h50 + d_cnt), 32'h0);
      if (active) begin
        check_output("rr_cpu_gnt", bus1.cpu_gnt, (i % 2 == 0));
        check_output("rr_dma_gnt", bus1.dma_gnt, (i % 2 == 1));
        if (i % 2 == 0) c_cnt++;
        else d_cnt++;
      end
      check_output("rr_cpu_rvalid", bus1.cpu_rvalid, (i >= 1 && i <= 8 && (i - 1) % 2 == 0));
      check_output("rr_dma_rvalid", bus1.dma_rvalid, (i >= 2 && i <= 8 && (i - 1) % 2 == 1));
      if (bus1.cpu_rvalid) begin
        check_output("rr_cpu_rdata", bus1.cpu_rdata, mem_init(8'h40 + rv_c));
        rv_c++;
      end
      if (bus1.dma_rvalid) begin
        check_output("rr_dma_rdata", bus1.dma_rdata, mem_init(8'h50 + rv_d));
        rv_d++;
      end
    end
    check_output("rr_cpu_count", 64'(rv_c), 64'd4);
    check_output("rr_dma_count", 64'(rv_d), 64'd4);

    // DMA write lands in the same cycle a CPU read of that address returns.
    apply_stimulus(1, 0, 8'h20, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("wr_rd_cpu_gnt", bus1.cpu_gnt, 1'b1);
    apply_stimulus(0, 0, 8'h00, 32'h0, 1, 1, 8'h20, 32'h0000_00A5);
    check_output("wr_rd_dma_gnt", bus1.dma_gnt, 1'b1);
    check_output("wr_rd_ram_we", bus1.ram_we, 1'b1);
    check_output("wr_rd_rvalid", bus1.cpu_rvalid, 1'b1);
    check_output("wr_rd_old_data", bus1.cpu_rdata, mem_init(8'h20));
    apply_stimulus(1, 0, 8'h20, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("wr_rd_cpu_gnt2", bus1.cpu_gnt, 1'b1);
    check_output("wr_rd_dma_norv", bus1.dma_rvalid, 1'b0);
    apply_stimulus(0, 0, 8'h00, 32'h0, 0, 0, 8'h00, 32'h0);
    check_output("wr_rd_rvalid2", bus1.cpu_rvalid, 1'b1);
    check_output("wr_rd_new_data", bus1.cpu_rdata, 32'h0000_00A5);

    // Latency 2: reset one cycle after a DMA read grant discards the read.
    @(negedge clock);
    bus2.dma_req  = 1'b1;
    bus2.dma_we   = 1'b0;
    bus2.dma_addr = 8'h30;
    #1;
    check_output("l2_dma_gnt", bus2.dma_gnt, 1'b1);
    check_output("l2_ram_re", bus2.ram_re, 1'b1);
    @(negedge clock);
    bus2.dma_req = 1'b0;
    #1;
    check_output("l2_busy", bus2.busy, 1'b1);
    check_output("l2_rvalid_early", bus2.dma_rvalid, 1'b0);
    reset = 1'b0;
    #1;
    check_output("l2_rst_busy", bus2.busy, 1'b0);
    check_output("l2_rst_rvalid", bus2.dma_rvalid, 1'b0);
    check_output("l2_rst_rdata", bus2.dma_rdata, 32'h0);
    @(negedge clock);
    #1;
    check_output("l2_rst_rvalid2", bus2.dma_rvalid, 1'b0);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      #1;
      check_output("l2_post_rvalid", bus2.dma_rvalid, 1'b0);
      check_output("l2_post_busy", bus2.busy, 1'b0);
    end

    // Latency 4: four back-to-back CPU reads return on consecutive cycles.
    for (int i = 0; i < 9; i++) begin
      @(negedge clock);
      bus4.cpu_req  = (i < 4);
      bus4.cpu_we   = 1'b0;
      bus4.cpu_addr = 8'(i);
      #1;
      if (i < 4) check_output("l4_cpu_gnt", bus4.cpu_gnt, 1'b1);
      if (i >= 1) check_output("l4_busy", bus4.busy, (i <= 7));
      check_output("l4_rvalid", bus4.cpu_rvalid, (i >= 4 && i <= 7));
      if (i >= 4 && i <= 7) check_output("l4_rdata", bus4.cpu_rdata, mem_init(i - 4));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 Parameters SHALL be: ADDR_W, default 8, RAM word-address width; DATA_W, default 32, data width; RD_LAT, default 1, RAM read latency in cycles (legal range 1..4).
REQ-002 clock  in  1  single clock; all state SHALL change on the rising edge.
REQ-003 reset  in  1  asynchronous, active-low reset.
REQ-004 cpu_req, cpu_we  in  1 each  CPU access request and write-select (MAR/MDR side).
REQ-005 cpu_addr  in  ADDR_W; cpu_wdata  in  DATA_W  CPU address and write data.
REQ-006 cpu_gnt  out  1  access accepted this cycle; cpu_rvalid  out  1  read data valid; cpu_rdata  out  DATA_W  read data.
REQ-007 dma_req, dma_we, dma_addr, dma_wdata, dma_gnt, dma_rvalid, dma_rdata SHALL mirror the cpu_* ports for the I/O/loader requester.
REQ-008 ram_addr  out  ADDR_W; ram_wdata  out  DATA_W; ram_we, ram_re  out  1; ram_rdata  in  DATA_W  single shared RAM port.
REQ-009 busy  out  1  high while any read is in flight.

Function
REQ-010 One RAM access SHALL be issued per cycle at most; back-to-back accesses SHALL be sustained at one per cycle.
REQ-011 cpu_gnt/dma_gnt SHALL be combinational from the req inputs and the priority state; at most one gnt SHALL be high per cycle.
REQ-012 An access SHALL complete on the rising edge at which req and gnt are both high; a requester SHALL hold req, we, addr and wdata stable until then.
REQ-013 ram_addr, ram_wdata, ram_we SHALL be the granted requester's signals; ram_re SHALL equal granted & !we; all ram strobes SHALL be 0 with no grant.
REQ-014 With one request pending, it SHALL be granted in the same cycle.
REQ-015 With both pending, the requester not granted last SHALL win (round-robin); last-granted SHALL update only on a completed access.
REQ-016 After reset, last-granted SHALL be DMA, so the CPU wins the first tie.
REQ-017 No requester SHALL wait more than one access by the other while continuously requesting.
REQ-018 Each granted read SHALL push an owner tag into an RD_LAT-deep shift register; on the cycle its tag exits, the owner's rvalid SHALL pulse for one cycle and ram_rdata SHALL route to its rdata.
REQ-019 Read data SHALL return in issue order, exactly RD_LAT cycles after the grant edge; writes produce no rvalid.
REQ-020 cpu_rdata/dma_rdata SHALL be held at their last delivered value when rvalid is low.
REQ-021 busy SHALL be high while any tag-pipeline slot is valid.
REQ-022 A write and a read-return in the same cycle SHALL both proceed without interference.

Reset
REQ-023 reset low SHALL immediately clear: tag pipeline (all slots invalid), rvalid both 0, rdata both 0, busy 0, last-granted to DMA.
REQ-024 Reads in flight at reset assertion SHALL be discarded; no rvalid SHALL pulse for them after reset releases.
REQ-025 gnt and ram strobes SHALL be 0 while reset is low, regardless of req.

Structure
REQ-026 A shared package SHALL hold the owner-tag enum (OWN_CPU, OWN_DMA) and the ADDR_W/DATA_W default constants.
REQ-027 The read-tag shift register SHALL be one sub-module, rd_tag_pipe, parameterised by RD_LAT.

Verification
REQ-028 CPU-only write 0x1234_5678 to addr 0x10, then read 0x10 -> cpu_gnt same cycle each; cpu_rvalid RD_LAT cycles after read grant; cpu_rdata = 0x1234_5678.
REQ-029 cpu_req and dma_req both high at first cycle after reset -> CPU granted first, DMA next cycle; ram_addr shows CPU then DMA address.
REQ-030 Both requesting reads continuously for 8 cycles -> grants alternate CPU, DMA, ...; 4 rvalids each, in order, none missing.
REQ-031 DMA writes 0xA5 to addr 0x20 while CPU read of 0x20 returns same cycle -> CPU gets old value; subsequent CPU read returns 0xA5.
REQ-032 reset asserted one cycle after a DMA read grant (RD_LAT=2) -> busy 0 immediately; no dma_rvalid after release.
REQ-033 RD_LAT=4, four consecutive CPU reads of 0x00..0x03 -> four cpu_rvalid pulses on consecutive cycles, busy high throughout, data in address order.
